// File: rtl/icache_line_fetcher.sv
// Instruction-cache refill engine: fetches one cache line over a narrow word port,
// critical word first with wrap-around, and returns the assembled line as a single pulse.
module icache_line_fetcher #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_req,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic                     ret_valid,
    output logic [32*LINE_WORDS-1:0] ret_data,
    output logic                     busy,
    output logic                     mem_req,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata
);

    localparam int OFS = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                         state, state_next;
    logic [ADDR_WIDTH-OFS-3:0]      line_hi;
    logic [OFS-1:0]                 idx;
    logic [OFS-1:0]                 idx_next;
    logic [OFS:0]                   cnt;
    logic                           last_word;
    logic [LINE_WORDS-1:0][31:0]    line_buf;

    assign idx_next  = idx + 1'b1;
    assign last_word = (cnt == (OFS+1)'(LINE_WORDS - 1));
    assign ret_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign ret_data  = line_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rd_req) state_next = REQ;
            REQ:  if (mem_gnt) state_next = WAIT;
            WAIT: if (mem_rvalid) state_next = last_word ? DONE : REQ;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mem_req/mem_addr are registered so the word port never sees combinational glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_hi  <= '0;
            idx      <= '0;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        line_hi  <= rd_addr[ADDR_WIDTH-1:OFS+2];
                        idx      <= rd_addr[OFS+1:2];
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= rd_addr & ~ADDR_WIDTH'(3);
                    end
                end
                REQ: begin
                    if (mem_gnt) mem_req <= 1'b0;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        line_buf[idx] <= mem_rdata;
                        idx           <= idx_next;
                        cnt           <= cnt + 1'b1;
                        if (!last_word) begin
                            mem_req  <= 1'b1;
                            mem_addr <= {line_hi, idx_next, 2'b00};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
